// File: rtl/mult_fu_if.sv
// Issue/completion bundle of the pipelined multiply functional unit.
// master = issue FIFO + complete stage side, slave = the multiply unit.
interface mult_fu_if #(
    parameter int XLEN      = 32,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
);
    logic                 in_valid;
    logic [1:0]           in_func;
    logic [XLEN-1:0]      in_rs1;
    logic [XLEN-1:0]      in_rs2;
    logic [PRF_IDX_W-1:0] in_dest_preg;
    logic [ROB_IDX_W-1:0] in_rob_idx;
    logic                 rd_en;
    logic                 out_valid;
    logic [XLEN-1:0]      out_value;
    logic [PRF_IDX_W-1:0] out_dest_preg;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    logic                 out_ack;

    modport master (
        output in_valid, in_func, in_rs1, in_rs2, in_dest_preg, in_rob_idx, out_ack,
        input  rd_en, out_valid, out_value, out_dest_preg, out_rob_idx
    );
    modport slave (
        input  in_valid, in_func, in_rs1, in_rs2, in_dest_preg, in_rob_idx, out_ack,
        output rd_en, out_valid, out_value, out_dest_preg, out_rob_idx
    );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined shift-and-add multiplier: each stage folds one multiplier chunk into
// a 2*XLEN partial sum; stages stall back from the completion handshake.
module mult_fu_stage #(
    parameter int XLEN      = 32,
    parameter int CHUNK     = 16,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 ld_en,
    input  logic                 up_vld,
    input  logic [1:0]           up_func,
    input  logic [PRF_IDX_W-1:0] up_preg,
    input  logic [ROB_IDX_W-1:0] up_rob,
    input  logic [2*XLEN-1:0]    up_mcand,
    input  logic [2*XLEN-1:0]    up_mplier,
    input  logic [2*XLEN-1:0]    up_psum,
    output logic                 vld,
    output logic [1:0]           func,
    output logic [PRF_IDX_W-1:0] preg,
    output logic [ROB_IDX_W-1:0] rob,
    output logic [2*XLEN-1:0]    mcand,
    output logic [2*XLEN-1:0]    mplier,
    output logic [2*XLEN-1:0]    psum
);
    logic [2*XLEN-1:0] chunk_z;

    always_comb begin
        chunk_z              = '0;
        chunk_z[CHUNK-1:0]   = up_mplier[CHUNK-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld    <= 1'b0;
            func   <= '0;
            preg   <= '0;
            rob    <= '0;
            mcand  <= '0;
            mplier <= '0;
            psum   <= '0;
        end else begin
            if (squash)     vld <= 1'b0;
            else if (ld_en) vld <= up_vld;
            // payload only moves with a live op so a drained last stage keeps its data
            if (ld_en && up_vld && !squash) begin
                func   <= up_func;
                preg   <= up_preg;
                rob    <= up_rob;
                mcand  <= up_mcand << CHUNK;
                mplier <= up_mplier >> CHUNK;
                psum   <= up_psum + up_mcand * chunk_z;
            end
        end
    end
endmodule

module mult_fu_pipe #(
    parameter int NUM_STAGE = 4,
    parameter int XLEN      = 32,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     squash,
    mult_fu_if.slave bus
);
    localparam int CHUNK = 2*XLEN/NUM_STAGE;
    localparam int LAST  = NUM_STAGE-1;
    localparam logic [1:0] FN_MUL    = 2'b00;
    localparam logic [1:0] FN_MULH   = 2'b01;
    localparam logic [1:0] FN_MULHSU = 2'b10;

    logic [NUM_STAGE-1:0]                vld_pipe;
    logic [NUM_STAGE-1:0]                adv;
    logic [NUM_STAGE:0]                  ready;
    logic [NUM_STAGE-1:0][1:0]           func_q;
    logic [NUM_STAGE-1:0][PRF_IDX_W-1:0] preg_q;
    logic [NUM_STAGE-1:0][ROB_IDX_W-1:0] rob_q;
    logic [NUM_STAGE-1:0][2*XLEN-1:0]    mcand_q, mplier_q, psum_q;
    logic                                signed_rs1, signed_rs2, accept;
    logic [2*XLEN-1:0]                   ext_rs1, ext_rs2;
    logic                                unused_tail;

    // ready[k]: stage k can take an op this cycle; ready[NUM_STAGE] is the completion ack
    always_comb begin
        adv              = '0;
        ready            = '0;
        ready[NUM_STAGE] = bus.out_ack;
        for (int k = LAST; k >= 0; k--) begin
            adv[k]   = vld_pipe[k] && ready[k+1];
            ready[k] = !vld_pipe[k] || adv[k];
        end
    end

    assign bus.rd_en = !reset && !squash && ready[0];
    assign accept    = bus.in_valid && bus.rd_en;

    assign signed_rs1 = (bus.in_func == FN_MULH) || (bus.in_func == FN_MULHSU);
    assign signed_rs2 = (bus.in_func == FN_MULH);
    assign ext_rs1    = {{XLEN{signed_rs1 & bus.in_rs1[XLEN-1]}}, bus.in_rs1};
    assign ext_rs2    = {{XLEN{signed_rs2 & bus.in_rs2[XLEN-1]}}, bus.in_rs2};

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        logic                 up_vld;
        logic [1:0]           up_func;
        logic [PRF_IDX_W-1:0] up_preg;
        logic [ROB_IDX_W-1:0] up_rob;
        logic [2*XLEN-1:0]    up_mcand, up_mplier, up_psum;

        if (k == 0) begin : g_head
            assign up_vld    = accept;
            assign up_func   = bus.in_func;
            assign up_preg   = bus.in_dest_preg;
            assign up_rob    = bus.in_rob_idx;
            assign up_mcand  = ext_rs1;
            assign up_mplier = ext_rs2;
            assign up_psum   = '0;
        end else begin : g_body
            assign up_vld    = vld_pipe[k-1];
            assign up_func   = func_q[k-1];
            assign up_preg   = preg_q[k-1];
            assign up_rob    = rob_q[k-1];
            assign up_mcand  = mcand_q[k-1];
            assign up_mplier = mplier_q[k-1];
            assign up_psum   = psum_q[k-1];
        end

        mult_fu_stage #(
            .XLEN(XLEN), .CHUNK(CHUNK), .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)
        ) u_stage (
            .clock(clock), .reset(reset), .squash(squash), .ld_en(ready[k]),
            .up_vld(up_vld), .up_func(up_func), .up_preg(up_preg), .up_rob(up_rob),
            .up_mcand(up_mcand), .up_mplier(up_mplier), .up_psum(up_psum),
            .vld(vld_pipe[k]), .func(func_q[k]), .preg(preg_q[k]), .rob(rob_q[k]),
            .mcand(mcand_q[k]), .mplier(mplier_q[k]), .psum(psum_q[k])
        );
    end

    // the last stage's shifted operands are fully consumed and feed nothing
    assign unused_tail = ^{mcand_q[LAST], mplier_q[LAST], adv};

    assign bus.out_valid     = vld_pipe[LAST];
    assign bus.out_value     = (func_q[LAST] == FN_MUL) ? psum_q[LAST][XLEN-1:0]
                                                        : psum_q[LAST][2*XLEN-1:XLEN];
    assign bus.out_dest_preg = preg_q[LAST];
    assign bus.out_rob_idx   = rob_q[LAST];
endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed + randomized checks of mult_fu_pipe at NUM_STAGE=4, XLEN=32.
module tb_mult_fu_pipe;
    localparam int NS = 4, XLEN = 32, PW = 6, RW = 5;
    localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

    logic clock = 1'b0;
    logic reset, squash;
    int   n_chk = 0, n_fail = 0;

    mult_fu_if #(.XLEN(XLEN), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) bus();

    mult_fu_pipe #(.NUM_STAGE(NS), .XLEN(XLEN), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) dut (
        .clock(clock), .reset(reset), .squash(squash), .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [PW-1:0] p, input logic [RW-1:0] r);
        bus.in_valid     = v;
        bus.in_func      = f;
        bus.in_rs1       = a;
        bus.in_rs2       = b;
        bus.in_dest_preg = p;
        bus.in_rob_idx   = r;
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            MULH:    p = sa * sb;
            MULHSU:  p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == MUL) ? p[31:0] : p[63:32];
    endfunction

    // single op with out_ack held high: result appears NS-1 edges after accept
    task automatic one(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        drive(1'b1, f, a, b, 6'd7, 5'd9);
        step();
        bus.in_valid = 1'b0;
        repeat (NS-1) step();
        chk({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
        chk(tag, 64'(bus.out_value), 64'(exp));
        step();
    endtask

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a, b, e;
    } vec_t;

    vec_t vecs[9] = '{
        '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
        '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
        '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
        '{MULHU,  32'h80000000, 32'h80000000, 32'h40000000},
        '{MULH,   32'h80000000, 32'h80000000, 32'h40000000},
        '{MULH,   32'h80000000, 32'h00000001, 32'hFFFFFFFF},
        '{MUL,    32'h12345678, 32'h00000010, 32'h23456780},
        '{MULHSU, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE}
    };

    initial begin
        logic [63:0] exp_q[$];
        logic [63:0] exp_pkt;
        int          sent, cyc;
        logic        accepted;

        reset = 1'b1;
        squash = 1'b0;
        bus.out_ack = 1'b0;
        drive(1'b1, MUL, 32'd3, 32'd3, 6'd1, 5'd1);

        // reset state, with in_valid asserted and ignored
        step();
        step();
        chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_value", 64'(bus.out_value), 64'd0);
        chk("rst_out_preg", 64'(bus.out_dest_preg), 64'd0);
        chk("rst_out_rob", 64'(bus.out_rob_idx), 64'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_rd_en", 64'(bus.rd_en), 64'd1);
        repeat (NS) step();
        chk("rst_no_ghost", 64'(bus.out_valid), 64'd0);

        // latency: 7*6 accepted at edge 0 shows after edge 3
        bus.out_ack = 1'b1;
        drive(1'b1, MUL, 32'd7, 32'd6, 6'd5, 5'd3);
        #1;
        chk("lat_rd_en", 64'(bus.rd_en), 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("lat_e0", 64'(bus.out_valid), 64'd0);
        step();
        chk("lat_e1", 64'(bus.out_valid), 64'd0);
        step();
        chk("lat_e2", 64'(bus.out_valid), 64'd0);
        step();
        chk("lat_e3_vld", 64'(bus.out_valid), 64'd1);
        chk("lat_e3_val", 64'(bus.out_value), 64'd42);
        chk("lat_e3_preg", 64'(bus.out_dest_preg), 64'd5);
        chk("lat_e3_rob", 64'(bus.out_rob_idx), 64'd3);
        step();
        chk("lat_gone", 64'(bus.out_valid), 64'd0);

        foreach (vecs[i]) one($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].e);

        // backpressure: four ops fill the pipe, the fifth waits for the drain
        bus.out_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, MUL, 32'(i+2), 32'd10, 6'(10+i), 5'(i));
            #1;
            chk($sformatf("bp_rd%0d", i), 64'(bus.rd_en), 64'd1);
            step();
        end
        drive(1'b1, MUL, 32'd6, 32'd10, 6'd14, 5'd4);
        #1;
        chk("bp_full_rd", 64'(bus.rd_en), 64'd0);
        chk("bp_head_vld", 64'(bus.out_valid), 64'd1);
        chk("bp_head_val", 64'(bus.out_value), 64'd20);
        step();
        chk("bp_hold_rob", 64'(bus.out_rob_idx), 64'd0);
        chk("bp_hold_val", 64'(bus.out_value), 64'd20);
        chk("bp_hold_rd", 64'(bus.rd_en), 64'd0);
        bus.out_ack = 1'b1;
        #1;
        chk("bp_ack_rd", 64'(bus.rd_en), 64'd1);
        step();
        bus.in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("bp_drain_vld%0d", j), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp_drain_rob%0d", j), 64'(bus.out_rob_idx), 64'(j));
            chk($sformatf("bp_drain_val%0d", j), 64'(bus.out_value), 64'((j+2)*10));
            step();
        end
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // squash with three ops in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, MUL, 32'(i+1), 32'd3, 6'd20, 5'(20+i));
            step();
        end
        squash = 1'b1;
        drive(1'b1, MUL, 32'd9, 32'd9, 6'd21, 5'd25);
        #1;
        chk("sq_rd_en", 64'(bus.rd_en), 64'd0);
        step();
        squash = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("sq_out_valid", 64'(bus.out_valid), 64'd0);
        chk("sq_rd_after", 64'(bus.rd_en), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sq_none%0d", i), 64'(bus.out_valid), 64'd0);
        end

        // reset with a full, stalled pipe
        bus.out_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, MULHU, 32'hFFFF0000, 32'(i+5), 6'd30, 5'(i+8));
            step();
        end
        chk("rs_full_vld", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_out_value", 64'(bus.out_value), 64'd0);
        chk("rs_out_preg", 64'(bus.out_dest_preg), 64'd0);
        chk("rs_out_rob", 64'(bus.out_rob_idx), 64'd0);
        bus.out_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rs_stale%0d", i), 64'(bus.out_valid), 64'd0);
        end

        // random ops against the 64-bit reference, random completion stalls
        sent = 0;
        cyc = 0;
        bus.in_valid = 1'b0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            bus.out_ack = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && sent < 1000 && $urandom_range(0, 4) != 0)
                drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom,
                      6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
            #1;
            if (bus.out_valid && bus.out_ack) begin
                if (exp_q.size() == 0) chk("rnd_spurious", 64'd1, 64'd0);
                else begin
                    exp_pkt = exp_q.pop_front();
                    chk("rnd", 64'({bus.out_dest_preg, bus.out_rob_idx, bus.out_value}), exp_pkt);
                end
            end
            accepted = bus.in_valid && bus.rd_en;
            if (accepted) begin
                exp_q.push_back(64'({bus.in_dest_preg, bus.in_rob_idx,
                                     ref_mul(bus.in_func, bus.in_rs1, bus.in_rs2)}));
                sent++;
            end
            step();
            if (accepted) bus.in_valid = 1'b0;
            cyc++;
        end
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        chk("rnd_sent", 64'(sent), 64'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
